// File: rtl/synth_pkg.sv
// Shared definitions for the key-to-period selector.
//   PERIOD_TABLE : half-periods (clk ticks) for one octave of 12 keys, lowest note first
//   prio_mode_e  : note priority selection
//   sel_state_e  : selector FSM states
//   key_period() : half-period of a key index after octave shifting, never 0
package synth_pkg;

  localparam int TABLE_LEN = 12;

  localparam logic [7:0] PERIOD_TABLE [TABLE_LEN] = '{
    8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69,
    8'd65, 8'd61, 8'd58, 8'd55, 8'd52, 8'd49
  };

  typedef enum logic [1:0] {
    PRIO_LOWEST     = 2'd0,
    PRIO_HIGHEST    = 2'd1,
    PRIO_LAST       = 2'd2,
    PRIO_LOWEST_ALT = 2'd3
  } prio_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GLIDE = 2'd2
  } sel_state_e;

  // Each 12 keys up is one octave (period halves); the octave input adds more halving.
  // A period of 0 would stall the tone counter, so it is clamped to 1.
  function automatic logic [7:0] key_period(input int unsigned idx, input int unsigned oct);
    logic [7:0] p;
    p = PERIOD_TABLE[4'(idx % TABLE_LEN)] >> (idx / TABLE_LEN + oct);
    if (p == 8'd0) p = 8'd1;
    return p;
  endfunction

endpackage

// File: rtl/period_glide.sv
// Slew register for the tone half-period.
//   clk, rst     : clock, async active-high reset
//   target       : desired half-period
//   load         : jump straight to target (also restarts the step counter)
//   glide_en     : glide active; every GLIDE_DIV cycles move 1 LSB toward target
//   half_period  : current half-period
module period_glide #(
  parameter int PERIOD_W  = 8,
  parameter int GLIDE_DIV = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] target,
  input  logic                load,
  input  logic                glide_en,
  output logic [PERIOD_W-1:0] half_period
);

  localparam int CW = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GLIDE_DIV - 1);

  logic [CW-1:0]       cnt_reg;
  logic [PERIOD_W-1:0] hp_reg;

  // The counter keeps running across target changes so a retargeted glide
  // keeps its step cadence; it only restarts on a load or when gliding stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      hp_reg  <= '0;
    end else if (load) begin
      cnt_reg <= '0;
      hp_reg  <= target;
    end else if (glide_en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        if (hp_reg < target)      hp_reg <= hp_reg + 1'b1;
        else if (hp_reg > target) hp_reg <= hp_reg - 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  assign half_period = hp_reg;

endmodule

// File: rtl/wave_period_selector_v2.sv
// Maps NUM_KEYS key levels to the square-wave half-period.
//   clk, rst     : clock, async active-high reset
//   keys         : raw key levels, bit0 = lowest note
//   prio_mode    : 0 lowest, 1 highest, 2 last-pressed, 3 lowest
//   octave       : extra octave shift (right shift of period)
//   glide_en     : slew the period toward a new target instead of jumping
//   half_period  : half-period to the tone generator
//   note_idx     : selected key index
//   gate         : any key held
//   note_change  : one-cycle pulse on note change or gate rise
// Pipeline: 2 sync flops, then the FSM/output register -> 3 cycles key to output.
module wave_period_selector_v2
  import synth_pkg::*;
#(
  parameter int NUM_KEYS  = 12,
  parameter int PERIOD_W  = 8,
  parameter int GLIDE_DIV = 64,
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          prio_mode,
  input  logic [1:0]          octave,
  input  logic                glide_en,
  output logic [PERIOD_W-1:0] half_period,
  output logic [IW-1:0]       note_idx,
  output logic                gate,
  output logic                note_change
);

  logic [NUM_KEYS-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [IW-1:0]       last_reg;
  sel_state_e          state_reg;
  logic [IW-1:0]       note_idx_reg;
  logic                gate_reg, note_change_reg;

  logic [NUM_KEYS-1:0] rise;
  logic [IW-1:0]       low_idx, high_idx, rise_idx, sel_idx;
  logic                any_key, last_held;
  logic [PERIOD_W-1:0] target, hp;
  logic                load, step_en;

  // sync3_reg is the previous synchronized sample, used only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= keys;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign rise      = sync2_reg & ~sync3_reg;
  assign any_key   = |sync2_reg;
  assign last_held = sync2_reg[last_reg];

  // Priority encoders: descending scan leaves the lowest set index, ascending the highest.
  always_comb begin
    low_idx  = '0;
    high_idx = '0;
    rise_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync2_reg[i]) low_idx  = IW'(i);
      if (rise[i])      rise_idx = IW'(i);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync2_reg[i]) high_idx = IW'(i);
    end
  end

  // A fresh edge wins immediately so last-pressed has no extra cycle of lag.
  always_comb begin
    case (prio_mode_e'(prio_mode))
      PRIO_HIGHEST: sel_idx = high_idx;
      PRIO_LAST:    sel_idx = (|rise) ? rise_idx : (last_held ? last_reg : low_idx);
      default:      sel_idx = low_idx;
    endcase
  end

  assign target = PERIOD_W'(key_period(32'(sel_idx), 32'(octave)));

  always_comb begin
    load    = 1'b0;
    step_en = 1'b0;
    case (state_reg)
      IDLE:  load = any_key;
      HOLD:  load = any_key && !glide_en && (target != hp);
      GLIDE: begin
        load    = any_key && !glide_en;
        step_en = any_key && glide_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      note_idx_reg    <= '0;
      gate_reg        <= 1'b0;
      note_change_reg <= 1'b0;
      last_reg        <= '0;
    end else begin
      if (|rise) last_reg <= rise_idx;
      gate_reg        <= any_key;
      note_change_reg <= any_key && ((state_reg == IDLE) || (sel_idx != note_idx_reg));
      // note_idx (like half_period) freezes on release so the tail keeps its pitch.
      if (any_key) note_idx_reg <= sel_idx;
      case (state_reg)
        IDLE:  if (any_key) state_reg <= HOLD;
        HOLD: begin
          if (!any_key)                        state_reg <= IDLE;
          else if (glide_en && (target != hp)) state_reg <= GLIDE;
        end
        GLIDE: begin
          if (!any_key)                        state_reg <= IDLE;
          else if (!glide_en || (hp == target)) state_reg <= HOLD;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  period_glide #(
    .PERIOD_W  (PERIOD_W),
    .GLIDE_DIV (GLIDE_DIV)
  ) u_glide (
    .clk         (clk),
    .rst         (rst),
    .target      (target),
    .load        (load),
    .glide_en    (step_en),
    .half_period (hp)
  );

  assign half_period = hp;
  assign note_idx    = note_idx_reg;
  assign gate        = gate_reg;
  assign note_change = note_change_reg;

endmodule

// File: tb/tb_wave_period_selector_v2.sv
module tb_wave_period_selector_v2;

  localparam int NK = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] keys;
  logic [1:0]    prio_mode;
  logic [1:0]    octave;
  logic          glide_en;
  logic [7:0]    half_period;
  logic [4:0]    note_idx;
  logic          gate;
  logic          note_change;

  always #5 clk = ~clk;

  wave_period_selector_v2 #(
    .NUM_KEYS  (NK),
    .PERIOD_W  (8),
    .GLIDE_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .prio_mode   (prio_mode),
    .octave      (octave),
    .glide_en    (glide_en),
    .half_period (half_period),
    .note_idx    (note_idx),
    .gate        (gate),
    .note_change (note_change)
  );

  typedef struct {
    logic [NK-1:0] keys;
    logic [1:0]    mode;
    logic [1:0]    oct;
    int            hp;
    int            idx;
  } vec_t;

  typedef struct {
    int hp;
    int idx;
  } exp_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   table_hp [12] = '{92, 87, 82, 77, 73, 69, 65, 61, 58, 55, 52, 49};
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a key pattern, queue the expected result, then wait (bounded) for
  // the note_change pulse that marks the DUT output and compare against it.
  task automatic press_and_check(input logic [NK-1:0] k, input int hp, input int idx,
                                 input string name);
    bit   got;
    exp_t e;
    keys = k;
    sb_q.push_back('{hp, idx});
    got = 1'b0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (note_change) begin
        got = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    check({name, "_pulse"}, int'(got), 1);
    if (got) begin
      check({name, "_hp"}, int'(half_period), e.hp);
      check({name, "_idx"}, int'(note_idx), e.idx);
      check({name, "_gate"}, int'(gate), 1);
    end
    $display("[TB] %s keys=%h hp=%0d idx=%0d (exp %0d/%0d)", name, k, half_period, note_idx,
             e.hp, e.idx);
  endtask

  initial begin
    exp_t e;
    int   k;

    for (int i = 0; i < 12; i++) begin
      vecs[i].keys = 24'd1 << i;
      vecs[i].mode = 2'd0;
      vecs[i].oct  = 2'd0;
      vecs[i].hp   = table_hp[i];
      vecs[i].idx  = i;
    end
    vecs[12] = '{24'h000108, 2'd0, 2'd0, 77, 3};
    vecs[13] = '{24'h000108, 2'd1, 2'd0, 58, 8};
    vecs[14] = '{24'h000108, 2'd3, 2'd0, 77, 3};
    vecs[15] = '{24'h000001, 2'd0, 2'd2, 23, 0};
    vecs[16] = '{24'h001000, 2'd0, 2'd0, 46, 12};
    vecs[17] = '{24'h800000, 2'd0, 2'd3, 3, 23};

    rst = 1'b1; keys = '0; prio_mode = 2'd0; octave = 2'd0; glide_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hp", int'(half_period), 0);
    check("rst_idx", int'(note_idx), 0);
    check("rst_gate", int'(gate), 0);
    check("rst_nc", int'(note_change), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three-cycle latency from key edge to outputs.
    keys = 24'h1;
    repeat (2) @(negedge clk);
    check("lat_early_gate", int'(gate), 0);
    @(negedge clk);
    check("lat_gate", int'(gate), 1);
    check("lat_nc", int'(note_change), 1);
    check("lat_hp", int'(half_period), 92);
    @(negedge clk);
    check("lat_nc_drop", int'(note_change), 0);
    $display("[TB] latency hp=%0d gate=%0d", half_period, gate);

    for (int v = 0; v < NV; v++) begin
      keys = '0;
      repeat (5) @(negedge clk);
      prio_mode = vecs[v].mode;
      octave    = vecs[v].oct;
      press_and_check(vecs[v].keys, vecs[v].hp, vecs[v].idx, $sformatf("vec%0d", v));
    end
    octave = 2'd0;

    // Last-pressed priority with fallback to the lowest held key.
    keys = '0;
    repeat (5) @(negedge clk);
    prio_mode = 2'd2;
    press_and_check(24'h000008, 77, 3, "last_p3");
    repeat (3) @(negedge clk);
    press_and_check(24'h000108, 58, 8, "last_p8");
    repeat (3) @(negedge clk);
    press_and_check(24'h000008, 77, 3, "last_r8");

    keys = '0;
    repeat (4) @(negedge clk);
    check("rel_gate", int'(gate), 0);
    check("rel_hp", int'(half_period), 77);
    check("rel_idx", int'(note_idx), 3);
    $display("[TB] release gate=%0d hp=%0d", gate, half_period);

    // Glide 92 -> 87, one LSB per 4 cycles.
    prio_mode = 2'd1;
    glide_en  = 1'b1;
    press_and_check(24'h1, 92, 0, "glide_start");
    repeat (4) @(negedge clk);
    keys = 24'h3;
    for (k = 1; k <= 30; k++) begin
      if (k < 3) sb_q.push_back('{92, 0});
      else       sb_q.push_back('{92 - (((k - 3) / 4 > 5) ? 5 : (k - 3) / 4), 1});
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("glide_k%0d", k), int'(half_period), e.hp);
      if (k == 3) begin
        check("glide_nc", int'(note_change), 1);
        check("glide_idx", int'(note_idx), e.idx);
      end
      $display("[TB] glide k=%0d hp=%0d exp=%0d", k, half_period, e.hp);
    end

    keys = '0;
    repeat (4) @(negedge clk);
    check("glide_rel_gate", int'(gate), 0);
    check("glide_rel_hp", int'(half_period), 87);

    // Dropping glide_en mid-glide jumps to the target.
    press_and_check(24'h1, 92, 0, "drop_start");
    repeat (2) @(negedge clk);
    keys = 24'h3;
    repeat (8) @(negedge clk);
    check("drop_mid_hp", int'(half_period), 91);
    glide_en = 1'b0;
    @(negedge clk);
    check("drop_jump_hp", int'(half_period), 87);
    $display("[TB] glide drop hp=%0d", half_period);

    // Async reset mid-glide clears outputs without waiting for a clock edge.
    glide_en = 1'b1;
    keys = '0;
    repeat (4) @(negedge clk);
    press_and_check(24'h1, 92, 0, "rstg_start");
    repeat (2) @(negedge clk);
    keys = 24'h3;
    repeat (10) @(negedge clk);
    check("rstg_mid_hp", int'(half_period), 91);
    #2 rst = 1'b1;
    #1;
    check("rstg_hp", int'(half_period), 0);
    check("rstg_idx", int'(note_idx), 0);
    check("rstg_gate", int'(gate), 0);
    check("rstg_nc", int'(note_change), 0);
    $display("[TB] async reset hp=%0d gate=%0d", half_period, gate);
    @(negedge clk);
    rst = 1'b0;
    keys = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
